// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_pkg
//  Description : Shared pipeline definitions for the PC fetch path:
//                next-PC select encoding, branch-class constant and PC
//                increment helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // Next-PC select encoding; bit 1 marks an execute-stage redirect.
    typedef enum logic [1:0] {
        PC_SRC_SEQ      = 2'b00,   // sequential fetch, pc_f + 4
        PC_SRC_PRED     = 2'b01,   // predictor target for the fetch PC
        PC_SRC_TARGET   = 2'b10,   // resolved target from execute
        PC_SRC_ROLLBACK = 2'b11    // fall-through of the execute PC
    } pc_src_e;

    // Branch class value meaning "not a branch or jump".
    localparam logic [1:0]  BRANCH_OP_NONE = 2'b00;

    // Instruction size in bytes.
    localparam logic [31:0] C_PC_STEP      = 32'd4;

    // 32-bit modulo PC increment (0xFFFF_FFFC wraps to 0).
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + C_PC_STEP;
    endfunction

    // True when the select asks for an execute-stage redirect.
    function automatic logic is_redirect_src(input pc_src_e src);
        return (src == PC_SRC_TARGET) || (src == PC_SRC_ROLLBACK);
    endfunction

    // True when the branch class denotes a real branch or jump.
    function automatic logic is_branch_op(input logic [1:0] op);
        return op != BRANCH_OP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stage_reg
//  Description : One pipeline PC register (pc, pc_plus4, valid) with
//                hold enable and flush. A flushed or reset stage becomes a
//                bubble with all PC fields zeroed.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_stage_reg (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        valid_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Reset and flush both produce a zeroed bubble; flush beats the hold.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (en_i) begin
            r_pc       <= pc_i;
            r_pc_plus4 <= pc_plus4_i;
            r_valid    <= valid_i;
        end
    end

    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc_plus4;
    assign valid_o    = r_valid;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Fetch-stage program counter with next-PC selection,
//                F->D and D->E PC pipeline registers, a registered
//                redirect indication and saturating branch/misprediction
//                statistics counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_f_i,
    input  logic                 stall_d_i,
    input  logic                 stall_e_i,
    input  logic                 flush_d_i,
    input  logic                 flush_e_i,
    input  logic [1:0]           pc_src_i,
    input  logic [31:0]          pred_pc_target_f_i,
    input  logic [31:0]          pc_target_e_i,
    input  logic [1:0]           branch_op_e_i,
    input  logic                 cnt_clr_i,
    output logic [31:0]          pc_f_o,
    output logic [31:0]          pc_plus4_f_o,
    output logic [31:0]          pc_d_o,
    output logic [31:0]          pc_e_o,
    output logic [31:0]          pc_plus4_e_o,
    output logic                 valid_d_o,
    output logic                 valid_e_o,
    output logic                 redirect_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Fetch PC and next-PC selection
    // ------------------------------------------------------------------
    pc_src_e     w_pc_src;
    logic [31:0] r_pc_f;
    logic [31:0] w_pc_plus4_f;
    logic [31:0] w_pc_e;
    logic [31:0] w_pc_plus4_e;
    logic        w_valid_d;
    logic        w_valid_e;
    logic [31:0] w_pc_d;
    logic [31:0] w_pc_plus4_d;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_seq_sel;
    logic [31:0] w_pc_f_din;
    logic        w_redirect;
    logic        w_pc_f_load;
    logic        r_redirect;

    assign w_pc_src     = pc_src_e'(pc_src_i);
    assign w_pc_plus4_f = pc_inc(r_pc_f);

    // Full next-PC mux over all four select encodings.
    always_comb begin
        w_pc_next = w_pc_plus4_f;
        case (w_pc_src)
            PC_SRC_SEQ:      w_pc_next = w_pc_plus4_f;
            PC_SRC_PRED:     w_pc_next = pred_pc_target_f_i;
            PC_SRC_TARGET:   w_pc_next = pc_target_e_i;
            PC_SRC_ROLLBACK: w_pc_next = pc_inc(w_pc_e);
            default:         w_pc_next = w_pc_plus4_f;
        endcase
    end

    // Fetch-only selection used when no redirect is accepted: the
    // redirect bit is ignored and only the sequential/predicted choice
    // remains.
    always_comb begin
        w_pc_seq_sel = w_pc_plus4_f;
        if (pc_src_i[0]) begin
            w_pc_seq_sel = pred_pc_target_f_i;
        end
    end

    // A redirect from execute is accepted only while execute is moving;
    // it overrides a fetch stall because the fetched path is wrong.
    assign w_redirect  = is_redirect_src(w_pc_src) && !stall_e_i;
    assign w_pc_f_load = w_redirect || !stall_f_i;
    assign w_pc_f_din  = w_redirect ? w_pc_next : w_pc_seq_sel;

    // Fetch PC register: reset vector, redirect, or gated sequential load.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pc_f <= RESET_VECTOR;
        end else if (w_pc_f_load) begin
            r_pc_f <= w_pc_f_din;
        end
    end

    // One-cycle pulse marking that a redirect was taken on the last edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_redirect <= 1'b0;
        end else begin
            r_redirect <= w_redirect;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline PC registers
    // ------------------------------------------------------------------
    pc_stage_reg u_stage_d (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (!stall_d_i),
        .flush_i    (flush_d_i),
        .pc_i       (r_pc_f),
        .pc_plus4_i (w_pc_plus4_f),
        .valid_i    (1'b1),
        .pc_o       (w_pc_d),
        .pc_plus4_o (w_pc_plus4_d),
        .valid_o    (w_valid_d)
    );

    pc_stage_reg u_stage_e (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (!stall_e_i),
        .flush_i    (flush_e_i),
        .pc_i       (w_pc_d),
        .pc_plus4_i (w_pc_plus4_d),
        .valid_i    (w_valid_d),
        .pc_o       (w_pc_e),
        .pc_plus4_o (w_pc_plus4_e),
        .valid_o    (w_valid_e)
    );

    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispred_cnt;
    logic                 w_branch_inc;
    logic                 w_mispred_inc;

    // Both events use the pre-edge valid_e, so a redirect that also
    // flushes execute is still counted.
    assign w_branch_inc  = w_valid_e && !stall_e_i && is_branch_op(branch_op_e_i);
    assign w_mispred_inc = w_valid_e && w_redirect;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (reset_i || cnt_clr_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_branch_inc && (r_branch_cnt != C_CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
            end
            if (w_mispred_inc && (r_mispred_cnt != C_CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + C_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_f_o        = r_pc_f;
    assign pc_plus4_f_o  = w_pc_plus4_f;
    assign pc_d_o        = w_pc_d;
    assign pc_e_o        = w_pc_e;
    assign pc_plus4_e_o  = w_pc_plus4_e;
    assign valid_d_o     = w_valid_d;
    assign valid_e_o     = w_valid_e;
    assign redirect_o    = r_redirect;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 stall_f_i, stall_d_i, stall_e_i  input  1 each  hold the F-, D- and E-stage registers.
REQ-006 flush_d_i, flush_e_i  input  1 each  invalidate the D- and E-stage registers.
REQ-007 pc_src_i  input  2  next-PC select: 00 pc_f+4, 01 predicted target, 10 pc_target_e, 11 pc_e+4 (rollback).
REQ-008 pred_pc_target_f_i  input  32  predictor target for the F-stage PC.
REQ-009 pc_target_e_i  input  32  resolved branch/jump target from execute.
REQ-010 branch_op_e_i  input  2  E-stage branch class; 00 means not a branch/jump.
REQ-011 cnt_clr_i  input  1  synchronous clear of both statistics counters.
REQ-012 pc_f_o, pc_plus4_f_o, pc_d_o, pc_e_o, pc_plus4_e_o  output  32 each  PC and PC+4 per stage.
REQ-013 valid_d_o, valid_e_o  output  1 each  stage holds a real instruction, not a bubble.
REQ-014 redirect_o  output  1  registered; high for one cycle after a misprediction redirect is taken.
REQ-015 branch_cnt_o, mispred_cnt_o  output  CNT_WIDTH each  retired-branch and misprediction counts.

Function
REQ-016 The unit SHALL compute pc_next combinationally from pc_src_i; PC+4 adds are 32-bit modulo, and 32'hFFFF_FFFC+4 wraps to 0.
REQ-017 A redirect (pc_src_i[1]=1) SHALL load pc_next into pc_f when stall_e_i=0, even if stall_f_i=1.
REQ-018 When stall_e_i=1, pc_src_i[1] SHALL be ignored; PC holds if stall_f_i=1, else it loads the 00/01 selection per pc_src_i[0].
REQ-019 With no redirect and stall_f_i=0, pc_f SHALL load pc_next on each cycle; with stall_f_i=1 it SHALL hold.
REQ-020 The F->D register SHALL capture pc_f/pc_plus4_f with valid=1 unless stall_d_i=1 (hold); flush_d_i=1 SHALL clear valid_d and take priority over stall_d_i.
REQ-021 The D->E register SHALL work the same way with stall_e_i and flush_e_i; a bubble's PC fields SHALL be zeroed.
REQ-022 redirect_o SHALL be set in the cycle after an accepted redirect and SHALL otherwise be 0.
REQ-023 branch_cnt SHALL increment when valid_e_o=1, stall_e_i=0 and branch_op_e_i!=00.
REQ-024 mispred_cnt SHALL increment when an accepted redirect occurs with valid_e_o=1.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.
REQ-026 cnt_clr_i SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-027 Simultaneous flush_e_i and an E-stage redirect SHALL still count the redirect, because the count uses the pre-flush valid_e.

Reset
REQ-028 In any cycle with reset_i=1: pc_f=RESET_VECTOR, pc_plus4_f=RESET_VECTOR+4, all D/E fields=0, valid_d=valid_e=0, redirect_o=0, counters=0.
REQ-029 Reset SHALL override stall, flush, redirect and cnt_clr_i.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight state within that same clock edge.
REQ-031 Fetch SHALL resume from RESET_VECTOR on the first cycle after reset deasserts.

Structure
REQ-032 The pc_src encoding enum and the BRANCH_OP_NONE constant SHALL live in the shared pipeline package and be reused by the branch control logic.
REQ-033 The single sub-module pc_stage_reg (pc, pc_plus4 and valid, with en/flush/reset) SHALL be instantiated twice, once for D and once for E.
REQ-034 The counters SHALL be a generate-free saturating always block inside pc_fetch_unit.

Verification
REQ-035 Reset, then 3 cycles at pc_src=00 -> pc_f 0x0, 0x4, 0x8, 0xC; valid_e rises on the third cycle.
REQ-036 pc_src=01 with pred target 0x100 -> next pc_f=0x100; redirect_o stays 0.
REQ-037 pc_e=0x40, pc_src=11, stall_f=1, stall_e=0 -> pc_f=0x44, redirect_o=1 next cycle, mispred_cnt+1.
REQ-038 pc_src=10, target 0x200, stall_e=1 -> pc_f unchanged (stall_f=1), no count; after stall_e drops -> pc_f=0x200.
REQ-039 Preload mispred_cnt to 0xFFFF, force a redirect -> stays 0xFFFF; cnt_clr plus a redirect in the same cycle -> 0.
REQ-040 pc_f=0xFFFF_FFFC at pc_src=00 -> wraps to 0x0; reset mid-stream with flush_d=1 -> pc_f=RESET_VECTOR and all valids 0.
